// File: rtl/smg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices per-digit codes onto a shared segment bus.
// Optional per-slot brightness duty control when SMG_BRIGHTNESS_EN is defined.
module smg_scan_ctrl #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SEG_W          = 8,
    parameter logic [18:0] SCAN_TICKS     = 19'd49_999,
    parameter int unsigned BLANK_TICKS    = 1000,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [DIGITS*SEG_W-1:0]   Seg_Data_Bus,
    input  logic [DIGITS-1:0]         Digit_En,
    input  logic                      Scan_En,
`ifdef SMG_BRIGHTNESS_EN
    input  logic [3:0]                Brightness,
`endif
    output logic [SEG_W-1:0]          Row_Scan_Sig,
    output logic [DIGITS-1:0]         Column_Scan_Sig,
    output logic [$clog2(DIGITS)-1:0] Digit_Idx,
    output logic                      Frame_Done
);

    localparam int unsigned       IDX_W     = $clog2(DIGITS);
    localparam logic [18:0]       BLANK_CNT = 19'(BLANK_TICKS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [SEG_W-1:0]  SEG_OFF   = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e            st_q, st_d;
    logic [18:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEG_W-1:0]  code_q, code_d;
    logic              en_q, en_d;
    logic [SEG_W-1:0]  row_q, row_d;
    logic [DIGITS-1:0] col_q, col_d;
    logic [IDX_W-1:0]  didx_q;
    logic              done_q, done_d;
    logic              snap_sel, slot_end, show_on, active;
    logic [DIGITS-1:0] onehot;

    assign snap_sel = (st_q != StIdle) && (cnt_q == 19'd0);
    assign slot_end = (cnt_q == SCAN_TICKS);

    // Snapshot is transparent in the capture cycle so a zero-blank slot shows the live slice.
    assign code_d = snap_sel ? Seg_Data_Bus[idx_q*SEG_W +: SEG_W] : code_q;
    assign en_d   = snap_sel ? Digit_En[idx_q] : en_q;

`ifdef SMG_BRIGHTNESS_EN
    localparam logic [23:0] SHOW_LEN = 24'(SCAN_TICKS) + 24'd1 - 24'(BLANK_TICKS);

    logic [3:0]  bri_q, bri_d;
    logic [23:0] on_len;

    assign bri_d   = snap_sel ? Brightness : bri_q;
    assign on_len  = (SHOW_LEN * {20'd0, bri_d} + SHOW_LEN) >> 4;
    assign show_on = {5'd0, cnt_q - BLANK_CNT} < on_len;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) bri_q <= 4'd0;
        else        bri_q <= bri_d;
    end
`else
    assign show_on = 1'b1;
`endif

    always_comb begin
        cnt_d = 19'd0;
        idx_d = idx_q;
        st_d  = StIdle;
        if (!Scan_En) begin
            idx_d = '0;
        end else begin
            if (st_q == StIdle) begin
                cnt_d = 19'd0;
            end else if (slot_end) begin
                cnt_d = 19'd0;
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + 19'd1;
            end
            st_d = (cnt_d < BLANK_CNT) ? StBlank : StShow;
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
        active        = (st_q == StShow) && en_d && show_on;
        row_d         = SEG_OFF ^ (active ? code_d : '0);
        col_d         = SEL_OFF ^ (active ? onehot : '0);
        done_d        = (st_q != StIdle) && Scan_En && slot_end && (idx_q == LAST_IDX);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q   <= StIdle;
            cnt_q  <= 19'd0;
            idx_q  <= '0;
            code_q <= '0;
            en_q   <= 1'b0;
            row_q  <= SEG_OFF;
            col_q  <= SEL_OFF;
            didx_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            code_q <= code_d;
            en_q   <= en_d;
            row_q  <= row_d;
            col_q  <= col_d;
            didx_q <= idx_q;
            done_q <= done_d;
        end
    end

    assign Row_Scan_Sig    = row_q;
    assign Column_Scan_Sig = col_q;
    assign Digit_Idx       = didx_q;
    assign Frame_Done      = done_q;

endmodule
